fa_bist_checker: RTL

- Hardware self-test engine for the 1-bit FullAdder cell; it is the response side of the vector-driving flow.
- On start, it drives all 8 {A,B,Cin} input combinations into an attached full adder.
- After each vector it samples the sum and carry, compares them with a built-in golden result, and counts mismatches.
- It reports done/pass plus the first failing vector.
- It sits beside the FullAdder in a wrapper and replaces the manual waveform inspection step.

---
 rtl/fa_bist_pkg.sv | 16 +
 rtl/fa_bist_top.sv | 49 ++++
 rtl/full_adder.sv | 13 +
 rtl/fa_bist_checker.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fa_bist_pkg.sv
// Shared constants for the full-adder BIST checker.
// State encoding and vector bit positions used by checker and wrapper.
package fa_bist_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int NUM_VECTORS = 8;

    localparam int VEC_A_BIT   = 2;
    localparam int VEC_B_BIT   = 1;
    localparam int VEC_CIN_BIT = 0;

endpackage

// File: rtl/fa_bist_top.sv
// System-level unit: full adder cell plus its self-test checker.
module fa_bist_top
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 fail_valid,
    output logic [2:0]           fail_vec
);

    logic a, b, cin, fa_s, fa_c;

    FullAdder u_fa (
        .A   (a),
        .B   (b),
        .Cin (cin),
        .FaS (fa_s),
        .FaC (fa_c)
    );

    fa_bist_checker #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .ERR_CNT_W     (ERR_CNT_W)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dut_a      (a),
        .dut_b      (b),
        .dut_cin    (cin),
        .dut_s      (fa_s),
        .dut_cout   (fa_c),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec)
    );

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder cell exercised by the BIST checker.
module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic FaS,
    output logic FaC
);

    assign FaS = A ^ B ^ Cin;
    assign FaC = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/fa_bist_checker.sv
// Drives all 8 {A,B,Cin} vectors into a full adder and checks sum/carry.
// Reports done/pass, a saturating mismatch count and the first failing vector.
module fa_bist_checker
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 dut_a,
    output logic                 dut_b,
    output logic                 dut_cin,
    input  logic                 dut_s,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 fail_valid,
    output logic [2:0]           fail_vec
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;
    localparam logic [3:0]           SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0]           VEC_LAST    = 3'(NUM_VECTORS - 1);

    logic [1:0]           state_q, state_d;
    logic [2:0]           vec_q, vec_d;
    logic [3:0]           settle_q, settle_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 fail_valid_q, fail_valid_d;
    logic [2:0]           fail_vec_q, fail_vec_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 dut_a_q, dut_a_d;
    logic                 dut_b_q, dut_b_d;
    logic                 dut_cin_q, dut_cin_d;

    logic [1:0] expected;
    logic       mismatch;

    // Golden result comes from the operands actually on the wires.
    assign expected = {1'b0, dut_a_q} + {1'b0, dut_b_q} + {1'b0, dut_cin_q};
    assign mismatch = ({dut_cout, dut_s} != expected);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;

        unique case (state_q)
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = 4'd0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + 3'd1;
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                // IDLE and DONE both accept a fresh start.
                if (start) begin
                    state_d      = ST_DRIVE;
                    vec_d        = 3'd0;
                    settle_d     = 4'd0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = 3'd0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                end
            end
        endcase

        dut_a_d   = vec_d[VEC_A_BIT];
        dut_b_d   = vec_d[VEC_B_BIT];
        dut_cin_d = vec_d[VEC_CIN_BIT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= 3'd0;
            settle_q     <= 4'd0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            dut_a_q      <= 1'b0;
            dut_b_q      <= 1'b0;
            dut_cin_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            dut_a_q      <= dut_a_d;
            dut_b_q      <= dut_b_d;
            dut_cin_q    <= dut_cin_d;
        end
    end

    assign dut_a      = dut_a_q;
    assign dut_b      = dut_b_q;
    assign dut_cin    = dut_cin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule
